// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential word fetch, in-order memory requests,
// DEPTH-entry prefetch queue, redirect flush with drain of in-flight words.
// Ports: clk/rst (async, active-low); mem_req_o/mem_addr_o/mem_ack_i request,
// mem_rvalid_i/mem_rdata_i response; redirect_i/redirect_pc_i branch target;
// instr_valid_o/instr_o/instr_pc_o/instr_ready_i toward decode.
// Optional macro IFETCH_ALIGN_FAULT_EN adds fetch_fault_o (misaligned target).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef IFETCH_ALIGN_FAULT_EN
  ,
  output logic        fetch_fault_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIM = DEPTH[CW:0];
`ifdef IFETCH_ALIGN_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_state_nx;
  logic [31:0]   r_pc, w_pc_nx;
  logic [CW-1:0] r_out, w_out_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [AW-1:0] r_head, r_tail;
  logic          r_req, w_req_nx;
  logic          r_halt, w_halt_nx;
  logic [31:0]   r_qdata [DEPTH];
  logic [31:0]   r_qpc [DEPTH];

  logic          w_issue, w_rv, w_push, w_pop;
  logic          w_misalign;
  logic [31:0]   w_rsp_pc, w_tgt;
  logic [CW:0]   w_credit;

  assign w_issue = r_req & mem_ack_i;
  assign w_rv    = mem_rvalid_i & (r_out != '0);
  assign w_push  = w_rv & (r_state == S_RUN) & ~redirect_i;
  assign w_pop   = (r_cnt != '0) & instr_ready_i & ~redirect_i;

  // In RUN all outstanding requests are contiguous and end at pc-4,
  // so the oldest one (the responding one) sits at pc - 4*outstanding.
  assign w_rsp_pc = r_pc - {{(30-CW){1'b0}}, r_out, 2'b00};

  assign w_tgt      = {redirect_pc_i[31:2], 2'b00};
  assign w_misalign = FAULT_EN & (redirect_pc_i[1:0] != 2'b00);

  assign w_out_nx = r_out + CW'(w_issue) - CW'(w_rv);
  assign w_cnt_nx = redirect_i ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_credit = {1'b0, w_cnt_nx} + {1'b0, w_out_nx};

  always_comb begin
    w_state_nx = r_state;
    if (redirect_i) begin
      w_state_nx = (r_state == S_DRAIN || w_out_nx != '0) ? S_DRAIN : S_RUN;
    end else if (r_state == S_DRAIN && w_out_nx == '0) begin
      w_state_nx = S_RUN;
    end
  end

  always_comb begin
    w_pc_nx = r_pc;
    if (redirect_i)   w_pc_nx = w_tgt;
    else if (w_issue) w_pc_nx = r_pc + 32'd4;
  end

  assign w_halt_nx = redirect_i ? w_misalign : r_halt;

  // Request is registered from next-cycle state, so it never glitches
  // and is withdrawn the cycle after a redirect.
  assign w_req_nx = (w_state_nx == S_RUN) & ~w_halt_nx & (w_credit < LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_cnt   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_req   <= 1'b0;
      r_halt  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_qdata[i] <= '0;
        r_qpc[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_out   <= w_out_nx;
      r_cnt   <= w_cnt_nx;
      r_req   <= w_req_nx;
      r_halt  <= w_halt_nx;
      if (redirect_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_qdata[r_tail] <= mem_rdata_i;
          r_qpc[r_tail]   <= w_rsp_pc;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_pop) r_head <= r_head + 1'b1;
      end
    end
  end

  assign mem_req_o     = r_req;
  assign mem_addr_o    = r_pc;
  assign instr_valid_o = (r_cnt != '0);
  assign instr_o       = r_qdata[r_head];
  assign instr_pc_o    = r_qpc[r_head];

`ifdef IFETCH_ALIGN_FAULT_EN
  logic r_fault;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fault <= 1'b0;
    else      r_fault <= redirect_i & w_misalign;
  end
  assign fetch_fault_o = r_fault;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table vectors, directed corner sequences and a
// randomized run against a stream-level fetch scoreboard.
module tb_instruction_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_ready_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef IFETCH_ALIGN_FAULT_EN
  logic        fetch_fault_o;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_ready_i(instr_ready_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o)
`ifdef IFETCH_ALIGN_FAULT_EN
    ,
    .fetch_fault_o(fetch_fault_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        ack;
    logic        rv;
    logic [31:0] rva;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tab [10];

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;
  pend_t pend [$];

  int          ack_prob = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          cyc_n = 0;
  int          n_iss = 0;
  int          n_pops = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_iss = '0;
  logic        chk_flush = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic ack, input logic rv, input logic [31:0] rva,
                     input logic rdy, input logic rd, input logic [31:0] rpc);
    mem_ack_i     = ack;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? mdat(rva) : 32'h0;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    step();
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk);
    #2;
    rst = 1'b0;
    mem_ack_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    #1;
    if (check) begin
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", instr_pc_o, 32'h0);
    end
    @(negedge clk);
    step();
    rst = 1'b1;
    pend.delete();
    cyc_n = 0;
    n_iss = 0;
    exp_pc = '0;
    exp_iss = '0;
    chk_flush = 1'b0;
    hold_prev = 1'b0;
  endtask

  // One cycle with the bench memory model and the stream scoreboard.
  task automatic cyc();
    logic iss;
    int   due;
    if (chk_flush) chk("flush_valid", 32'(instr_valid_o), 32'd0);
    if (hold_prev) begin
      chk("hold_req", 32'(mem_req_o), 32'd1);
      chk("hold_addr", mem_addr_o, hold_addr);
    end
    mem_ack_i = (ack_prob >= 100) || (int'($urandom_range(0, 99)) < ack_prob);
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = mdat(pend[0].a);
      void'(pend.pop_front());
    end
    iss = mem_req_o & mem_ack_i;
    if (iss) begin
      chk("issue_addr", mem_addr_o, exp_iss);
      exp_iss += 32'd4;
      n_iss++;
      due = cyc_n + int'($urandom_range(lat_lo, lat_hi));
      if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
      pend.push_back('{a: mem_addr_o, due: due});
      n_tests++;
      if (pend.size() > DEPTH) begin
        n_fail++;
        $display("FAIL outstanding: got %0d, want <= %0d", pend.size(), DEPTH);
      end
    end
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      chk("pop_pc", instr_pc_o, exp_pc);
      chk("pop_instr", instr_o, mdat(exp_pc));
      exp_pc += 32'd4;
      n_pops++;
    end
    if (redirect_i) begin
      exp_pc = {redirect_pc_i[31:2], 2'b00};
      exp_iss = exp_pc;
    end
    chk_flush = redirect_i;
    hold_prev = mem_req_o & ~mem_ack_i & ~redirect_i;
    hold_addr = mem_addr_o;
    step();
    cyc_n++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int p0;
    // Streaming: ack every cycle, 1-cycle response, decode always ready.
    for (int i = 0; i < 10; i++) begin
      k = i + 1;
      tab[i].ack  = 1'b1;
      tab[i].rv   = (k >= 2);
      tab[i].rva  = 32'(4 * (k - 2));
      tab[i].rdy  = 1'b1;
      tab[i].req  = 1'b1;
      tab[i].addr = 32'(4 * (k - 1));
      tab[i].vld  = (k >= 3);
      tab[i].pc   = (k >= 3) ? 32'(4 * (k - 3)) : 32'h0;
    end

    do_reset(1'b1);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("tab_req", 32'(mem_req_o), 32'(tab[i].req));
      chk("tab_addr", mem_addr_o, tab[i].addr);
      chk("tab_valid", 32'(instr_valid_o), 32'(tab[i].vld));
      if (tab[i].vld) begin
        chk("tab_pc", instr_pc_o, tab[i].pc);
        chk("tab_instr", instr_o, mdat(tab[i].pc));
      end
      drv(tab[i].ack, tab[i].rv, tab[i].rva, tab[i].rdy, 1'b0, 32'h0);
    end

    // Fill the queue with decode stalled, then release one word at a time.
    do_reset(1'b1);
    ack_prob = 100;
    lat_lo = 1;
    lat_hi = 1;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    repeat (8) cyc();
    chk("full_issues", 32'(n_iss), 32'd4);
    chk("full_req", 32'(mem_req_o), 32'd0);
    chk("full_valid", 32'(instr_valid_o), 32'd1);
    chk("full_pc", instr_pc_o, 32'h0);
    chk("full_instr", instr_o, mdat(32'h0));
    instr_ready_i = 1'b1;
    cyc();
    chk("refill_req", 32'(mem_req_o), 32'd1);
    chk("refill_addr", mem_addr_o, 32'h10);
    instr_ready_i = 1'b0;
    cyc();
    instr_ready_i = 1'b1;
    cyc();
    chk("pushpop_valid", 32'(instr_valid_o), 32'd1);
    chk("pushpop_pc", instr_pc_o, 32'h8);
    repeat (12) cyc();
    chk("stream_pops", 32'(n_pops >= 12), 32'd1);

    // Redirect with three requests in flight: drain, then fetch target.
    do_reset(1'b0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("c_addr", mem_addr_o, 32'(4 * i));
      drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    chk("c_req4", 32'(mem_req_o), 32'd1);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", 32'(mem_req_o), 32'd0);
      chk("drain_valid", 32'(instr_valid_o), 32'd0);
      drv(1'b0, 1'b1, 32'(4 * i), 1'b1, 1'b0, 32'h0);
    end
    chk("post_drain_req", 32'(mem_req_o), 32'd1);
    chk("post_drain_addr", mem_addr_o, 32'h100);
    chk("post_drain_valid", 32'(instr_valid_o), 32'd0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    chk("tgt_valid", 32'(instr_valid_o), 32'd1);
    chk("tgt_pc", instr_pc_o, 32'h100);
    chk("tgt_instr", instr_o, mdat(32'h100));

    // Redirect with one outstanding answered in the same cycle: no drain.
    do_reset(1'b0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("d_addr", mem_addr_o, 32'h4);
    drv(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h200);
    chk("d_req", 32'(mem_req_o), 32'd1);
    chk("d_addr_tgt", mem_addr_o, 32'h200);
    chk("d_valid", 32'(instr_valid_o), 32'd0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("d_pc", instr_pc_o, 32'h200);
    chk("d_instr", instr_o, mdat(32'h200));

    // Address wrap at the top of the 32-bit space.
    do_reset(1'b0);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("w_addr0", mem_addr_o, 32'hFFFF_FFF8);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("w_addr1", mem_addr_o, 32'hFFFF_FFFC);
    drv(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0);
    chk("w_addr2", mem_addr_o, 32'h0);
    chk("w_req2", 32'(mem_req_o), 32'd1);
    chk("w_pc0", instr_pc_o, 32'hFFFF_FFF8);
    drv(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    chk("w_pc1", instr_pc_o, 32'hFFFF_FFFC);
    chk("w_instr1", instr_o, mdat(32'hFFFF_FFFC));

    // Misaligned redirect target.
    do_reset(1'b0);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h102);
`ifdef IFETCH_ALIGN_FAULT_EN
    chk("f_fault", 32'(fetch_fault_o), 32'd1);
    chk("f_req", 32'(mem_req_o), 32'd0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("f_fault_end", 32'(fetch_fault_o), 32'd0);
    chk("f_req_hold", 32'(mem_req_o), 32'd0);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("f_req_hold2", 32'(mem_req_o), 32'd0);
    chk("f_valid", 32'(instr_valid_o), 32'd0);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104);
    chk("f_req_new", 32'(mem_req_o), 32'd1);
    chk("f_addr_new", mem_addr_o, 32'h104);
    chk("f_fault_new", 32'(fetch_fault_o), 32'd0);
`else
    chk("m_req", 32'(mem_req_o), 32'd1);
    chk("m_addr", mem_addr_o, 32'h100);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("m_addr_next", mem_addr_o, 32'h104);
`endif

    // Randomized traffic against the stream scoreboard.
    do_reset(1'b0);
    ack_prob = 70;
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        redirect_pc_i = $urandom();
`ifdef IFETCH_ALIGN_FAULT_EN
      redirect_pc_i[1:0] = 2'b00;
`endif
      cyc();
    end
    redirect_i = 1'b0;
    instr_ready_i = 1'b1;
    ack_prob = 100;
    p0 = n_pops;
    for (int i = 0; i < 200 && (n_pops - p0) < 20; i++) cyc();
    chk("liveness", 32'((n_pops - p0) >= 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
